// File: rtl/token_run_length_encoder.sv
// Token run-length encoder: measures runs of consecutive 1 tokens and queues each
// completed length in a small FIFO behind a valid/ready word interface.
module token_run_length_encoder #(
   parameter int W       = 8,
   parameter int MAX_RUN = 200,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a,
   output logic                     len_valid,
   input  logic                     len_ready,
   output logic [W-1:0]             len_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [W-1:0]  CNT_SAT   = '1;
   localparam logic [W-1:0]  RUN_LIMIT = W'(MAX_RUN);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

   logic [W-1:0]            run_cnt_q, run_cnt_d;
   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic                    overflow_q, overflow_d;
   logic                    drop_q, drop_d;

   logic run_end;
   logic full;
   logic pop;
   logic push;

   assign len_valid  = (level_q != '0);
   assign len_data   = mem_q[rd_ptr_q];
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign drop       = drop_q;

   assign run_end = !a && (run_cnt_q != '0);
   assign full    = (level_q == LVL_FULL);
   assign pop     = len_valid && len_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   assign push    = run_end && (!full || pop);

   always_comb begin
      run_cnt_d  = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      level_d    = level_q + LW'(push) - LW'(pop);

      if (a) begin
         run_cnt_d = (run_cnt_q == CNT_SAT) ? run_cnt_q : run_cnt_q + W'(1);
         if (run_cnt_q == RUN_LIMIT)
            overflow_d = 1'b1;
      end

      if (push)
         wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)
         rd_ptr_d = rd_ptr_q + AW'(1);
      if (run_end && !push)
         drop_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_cnt_q  <= '0;
         mem_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         run_cnt_q  <= run_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         if (push)
            mem_q[wr_ptr_q] <= run_cnt_q;
      end
   end

endmodule

// File: tb/tb_token_run_length_encoder.sv
// Directed bench for token_run_length_encoder: reset, basic runs, backpressure,
// full-with-pop, overflow boundary and counter saturation.
module tb_token_run_length_encoder;

   logic       clk;
   logic       rst;
   logic       a;
   logic       len_valid;
   logic       len_ready;
   logic [7:0] len_data;
   logic [2:0] fifo_level;
   logic       overflow;
   logic       drop;

   int checks;
   int errors;

   token_run_length_encoder #(.W(8), .MAX_RUN(200), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .a          (a),
      .len_valid  (len_valid),
      .len_ready  (len_ready),
      .len_data   (len_data),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .drop       (drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      a = 1'b0;
      len_ready = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", len_valid); end
      checks++; if (len_data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", len_data); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
      checks++; if (overflow !== 1'b0 || drop !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%0b drop=%0b exp 0 0", overflow, drop); end
      rst = 1'b1;
      // leave one entry queued, then open a run and reset in the middle of it
      a = 1'b1; tick();
      a = 1'b0; tick();
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL pre_reset_level got %0d exp 1", fifo_level); end
      a = 1'b1; tick(); tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (len_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL midreset_fifo got valid=%0b level=%0d exp 0 0", len_valid, fifo_level); end
      checks++; if (len_data !== 8'd0) begin errors++; $display("FAIL midreset_data got %0d exp 0", len_data); end
      a = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL aborted_run_pushed got level %0d exp 0", fifo_level); end
      a = 1'b1; tick();
      a = 1'b0; tick();
      checks++; if (len_valid !== 1'b1 || len_data !== 8'd1) begin errors++; $display("FAIL post_reset_run got valid=%0b data=%0d exp 1 1", len_valid, len_data); end
      len_ready = 1'b1; tick();
      checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL post_reset_pop got valid=%0b exp 0", len_valid); end
      tick();
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ready_while_empty got level %0d exp 0", fifo_level); end
      len_ready = 1'b0;
   endtask

   task automatic test_basic();
      logic [0:9] a_seq;
      logic [0:9] exp_v;
      int         exp_d[10];
      a_seq = 10'b1001101110;
      exp_v = 10'b0100010001;
      exp_d = '{0, 1, 0, 0, 0, 2, 0, 0, 0, 3};
      apply_reset();
      len_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a = a_seq[i];
         tick();
         checks++; if (len_valid !== exp_v[i]) begin errors++; $display("FAIL basic_valid[%0d] got %0b exp %0b", i, len_valid, exp_v[i]); end
         if (exp_v[i]) begin
            checks++; if (len_data !== 8'(exp_d[i])) begin errors++; $display("FAIL basic_data[%0d] got %0d exp %0d", i, len_data, exp_d[i]); end
         end
      end
      a = 1'b0; tick();
      checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got valid=%0b exp 0", len_valid); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      for (int r = 1; r <= 5; r++) begin
         a = 1'b1;
         for (int k = 0; k < r; k++) tick();
         a = 1'b0; tick();
         if (r == 4) begin
            checks++; if (fifo_level !== 3'd4 || drop !== 1'b0) begin errors++; $display("FAIL bp_full got level=%0d drop=%0b exp 4 0", fifo_level, drop); end
         end
      end
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d exp 4", fifo_level); end
      checks++; if (drop !== 1'b1) begin errors++; $display("FAIL bp_drop got %0b exp 1", drop); end
      tick(); tick();
      checks++; if (len_valid !== 1'b1 || len_data !== 8'd1) begin errors++; $display("FAIL bp_stable got valid=%0b data=%0d exp 1 1", len_valid, len_data); end
      len_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checks++; if (len_valid !== 1'b1 || len_data !== 8'(k)) begin errors++; $display("FAIL bp_order[%0d] got valid=%0b data=%0d exp 1 %0d", k, len_valid, len_data, k); end
         tick();
      end
      checks++; if (fifo_level !== 3'd0 || len_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got level=%0d valid=%0b exp 0 0", fifo_level, len_valid); end
      checks++; if (drop !== 1'b1) begin errors++; $display("FAIL bp_drop_sticky got %0b exp 1", drop); end
      len_ready = 1'b0;
   endtask

   task automatic test_full_pop();
      int exp_q[4];
      exp_q = '{2, 3, 4, 7};
      apply_reset();
      for (int r = 1; r <= 4; r++) begin
         a = 1'b1;
         for (int k = 0; k < r; k++) tick();
         a = 1'b0; tick();
      end
      a = 1'b1;
      for (int k = 0; k < 7; k++) tick();
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fp_full got level %0d exp 4", fifo_level); end
      a = 1'b0;
      len_ready = 1'b1;
      tick();
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fp_level got %0d exp 4", fifo_level); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL fp_drop got %0b exp 0", drop); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (len_valid !== 1'b1 || len_data !== 8'(exp_q[k])) begin errors++; $display("FAIL fp_order[%0d] got valid=%0b data=%0d exp 1 %0d", k, len_valid, len_data, exp_q[k]); end
         tick();
      end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL fp_empty got level %0d exp 0", fifo_level); end
      len_ready = 1'b0;
   endtask

   task automatic test_overflow();
      apply_reset();
      len_ready = 1'b1;
      a = 1'b1;
      for (int k = 0; k < 200; k++) tick();
      a = 1'b0; tick();
      checks++; if (len_valid !== 1'b1 || len_data !== 8'd200) begin errors++; $display("FAIL ovf_200_data got valid=%0b data=%0d exp 1 200", len_valid, len_data); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_200_flag got %0b exp 0", overflow); end
      tick();
      a = 1'b1;
      for (int k = 0; k < 200; k++) tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_201 got %0b exp 0", overflow); end
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_201 got %0b exp 1", overflow); end
      a = 1'b0; tick();
      checks++; if (len_valid !== 1'b1 || len_data !== 8'd201) begin errors++; $display("FAIL ovf_201_data got valid=%0b data=%0d exp 1 201", len_valid, len_data); end
      tick();
      a = 1'b1; tick(); tick();
      a = 1'b0; tick();
      checks++; if (len_data !== 8'd2 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got data=%0d ovf=%0b exp 2 1", len_data, overflow); end
      tick();
      len_ready = 1'b0;
   endtask

   task automatic test_saturation();
      apply_reset();
      len_ready = 1'b1;
      a = 1'b1;
      for (int k = 0; k < 300; k++) tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf got %0b exp 1", overflow); end
      a = 1'b0; tick();
      checks++; if (len_valid !== 1'b1 || len_data !== 8'd255) begin errors++; $display("FAIL sat_data got valid=%0b data=%0d exp 1 255", len_valid, len_data); end
      tick();
      a = 1'b1; tick(); tick(); tick();
      a = 1'b0; tick();
      checks++; if (len_data !== 8'd3) begin errors++; $display("FAIL sat_next_run got %0d exp 3", len_data); end
      tick();
      len_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      a = 1'b0;
      len_ready = 1'b0;
      #2 rst = 1'b0;
      tick();
      test_reset();
      test_basic();
      test_backpressure();
      test_full_pop();
      test_overflow();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
